// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping datapath: ms/sec/min/hr counters with per-field up/down strobes
// and combinational carryups. Define STOPWATCH_LAP_EN to add the lap capture registers.
module stopwatch_counter #(
  parameter int unsigned MS_MAX  = 999,
  parameter int unsigned SEC_MAX = 59,
  parameter int unsigned MIN_MAX = 59,
  parameter int unsigned HR_MAX  = 99
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_ms_up,
  input  logic        i_ms_down,
  input  logic        i_sec_up,
  input  logic        i_sec_down,
  input  logic        i_min_up,
  input  logic        i_min_down,
  input  logic        i_hr_up,
  input  logic        i_hr_down,
`ifdef STOPWATCH_LAP_EN
  input  logic        i_lap,
  output logic [9:0]  o_lap_ms,
  output logic [5:0]  o_lap_sec,
  output logic [5:0]  o_lap_min,
  output logic [6:0]  o_lap_hr,
`endif
  output logic [9:0]  o_ms,
  output logic [5:0]  o_sec,
  output logic [5:0]  o_min,
  output logic [6:0]  o_hr,
  output logic        o_ms_carryup,
  output logic        o_sec_carryup,
  output logic        o_min_carryup,
  output logic        o_hr_carryup
);

  localparam int unsigned MS_W  = 10;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 7;
  localparam int unsigned CALC_W = 10;

  localparam logic [MS_W-1:0]  MS_MAX_V  = MS_W'(MS_MAX);
  localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] MIN_MAX_V = MIN_W'(MIN_MAX);
  localparam logic [HR_W-1:0]  HR_MAX_V  = HR_W'(HR_MAX);

  logic [MS_W-1:0]  ms_q,  ms_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HR_W-1:0]  hr_q,  hr_d;

  // Per-field {up,down} decode; out-of-range values wrap to 0 on increment.
  function automatic logic [CALC_W-1:0] next_val(input logic [CALC_W-1:0] cur,
                                                 input logic [CALC_W-1:0] max_v,
                                                 input logic up, input logic down);
    logic [CALC_W-1:0] nv;
    nv = cur;
    case ({up, down})
      2'b10:   nv = (cur >= max_v) ? '0 : cur + CALC_W'(1);
      2'b01:   nv = (cur == '0) ? max_v : cur - CALC_W'(1);
      2'b11:   nv = '0;
      default: nv = cur;
    endcase
    return nv;
  endfunction

  always_comb begin
    ms_d  = MS_W'(next_val(CALC_W'(ms_q), CALC_W'(MS_MAX_V), i_ms_up, i_ms_down));
    sec_d = SEC_W'(next_val(CALC_W'(sec_q), CALC_W'(SEC_MAX_V), i_sec_up, i_sec_down));
    min_d = MIN_W'(next_val(CALC_W'(min_q), CALC_W'(MIN_MAX_V), i_min_up, i_min_down));
    hr_d  = HR_W'(next_val(CALC_W'(hr_q), CALC_W'(HR_MAX_V), i_hr_up, i_hr_down));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ms_q  <= '0;
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
    end else begin
      ms_q  <= ms_d;
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
    end
  end

  // Carryups depend only on own state and own strobes, so the external ripple chain has no loop.
  assign o_ms_carryup  = i_ms_up  & ~i_ms_down  & (ms_q  == MS_MAX_V);
  assign o_sec_carryup = i_sec_up & ~i_sec_down & (sec_q == SEC_MAX_V);
  assign o_min_carryup = i_min_up & ~i_min_down & (min_q == MIN_MAX_V);
  assign o_hr_carryup  = i_hr_up  & ~i_hr_down  & (hr_q  == HR_MAX_V);

  assign o_ms  = ms_q;
  assign o_sec = sec_q;
  assign o_min = min_q;
  assign o_hr  = hr_q;

`ifdef STOPWATCH_LAP_EN
  logic clear_all;
  assign clear_all = i_ms_up & i_ms_down & i_sec_up & i_sec_down &
                     i_min_up & i_min_down & i_hr_up & i_hr_down;

  // Lap snapshots pre-edge field values; a full clear wins over a lap request.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_lap_ms  <= '0;
      o_lap_sec <= '0;
      o_lap_min <= '0;
      o_lap_hr  <= '0;
    end else if (clear_all) begin
      o_lap_ms  <= '0;
      o_lap_sec <= '0;
      o_lap_min <= '0;
      o_lap_hr  <= '0;
    end else if (i_lap) begin
      o_lap_ms  <= ms_q;
      o_lap_sec <= sec_q;
      o_lap_min <= min_q;
      o_lap_hr  <= hr_q;
    end
  end
`endif

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Time-keeping datapath for the stopwatch; the counter end of the up/down/carryup interface driven by the stopwatch control block.
- Holds ms, sec, min and hr fields.
- Applies per-field up/down strobes.
- Returns the per-field carryup signals that the control block gates into the next field's up strobe.
- Outputs feed the display mux.

Parameters:
MS_MAX, 999, terminal value of ms field (must fit 10 bits)
SEC_MAX, 59, terminal value of sec field (must fit 6 bits)
MIN_MAX, 59, terminal value of min field (must fit 6 bits)
HR_MAX, 99, terminal value of hr field (must fit 7 bits)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rstn  input  1  reset; asynchronous, active-low
i_ms_up  input  1  ms increment strobe
i_ms_down  input  1  ms decrement strobe
i_sec_up  input  1  sec increment strobe
i_sec_down  input  1  sec decrement strobe
i_min_up  input  1  min increment strobe
i_min_down  input  1  min decrement strobe
i_hr_up  input  1  hr increment strobe
i_hr_down  input  1  hr decrement strobe
o_ms  output  10  ms field
o_sec  output  6  sec field
o_min  output  6  min field
o_hr  output  7  hr field
o_ms_carryup  output  1  ms wraps this edge
o_sec_carryup  output  1  sec wraps this edge
o_min_carryup  output  1  min wraps this edge
o_hr_carryup  output  1  hr overflows this edge

Behaviour:
- Reset (i_rstn low, asynchronous): all fields 0. All carryups are 0 as a consequence.
- Each field is an independent registered counter, 0..X_MAX. The {up,down} pair is decoded per field each rising edge:
  - 00: hold.
  - 10: increment; at X_MAX, wrap to 0.
  - 01: decrement; at 0, wrap to X_MAX. No borrow output; decrement never touches other fields.
  - 11: clear to 0. The control block raises all up/down together for set/clear. Clear is idempotent while held.
- Carryups are combinational, with no register stage.
  - o_X_carryup = X_up & ~X_down & (field == X_MAX).
  - The control block ANDs each carryup with run and feeds it back as the next field's up strobe. A full ripple (e.g. 999/59/59 -> 0/0/0 plus hr+1) therefore completes on the same edge as the ms wrap. There is no combinational loop, because carryup depends only on own-field state and own strobes.
- o_hr_carryup: overflow indicator only. hr wraps HR_MAX -> 0; the higher level may latch it.
- Clear (11) and down never assert carryup.
- Field outputs are the registers directly: one-cycle latency from strobe to new value, and glitch-free.
- A field holding a value > X_MAX is unreachable. If forced, an increment wraps it to 0, and carryup is not asserted.

Optional Feature:
Macro STOPWATCH_LAP_EN.
- Defined:
  - Adds input i_lap (1) and outputs o_lap_ms (10), o_lap_sec (6), o_lap_min (6), o_lap_hr (7).
  - On a rising edge with i_lap=1, the lap registers capture the field values present before that edge. Increments on the same edge are not included.
  - Clear (all four fields strobed 11 on the same edge) also zeroes the lap registers. Clear has priority over i_lap.
  - Lap registers reset to 0 asynchronously.
- Undefined: no lap ports and no lap registers. Core behaviour is identical.

Test Plan:
- Reset asserted mid-count (fields 5/7/3/2) -> all fields 0 immediately, without waiting for a clock edge; carryups 0.
- ms=998, 2 edges of ms_up with sec_up=o_ms_carryup -> ms 999 then 0; o_ms_carryup high only during the second cycle; sec 0 -> 1 on that same edge.
- Full ripple: ms=999, sec=59, min=59, hr=3, one chained ms_up -> 0/0/0/4 in one edge; ms, sec and min carryups all high that cycle.
- hr=99 with hr_up -> hr 0, o_hr_carryup=1 for one cycle. ms=0 with ms_down -> ms 999, no carryup; sec unchanged.
- All up/down held high 3 cycles from 412/33/21/7 -> all 0 after the first edge, stay 0; no carryup asserted.
- LAP_EN: at 250/10/0/0 with i_lap plus ms_up on one edge -> lap reads 250/10/0/0, ms=251. Clear plus i_lap on the same edge -> lap 0.
